// File: rtl/decode_stage_pkg.sv
// Shared decode-stage definitions: opcodes, FSM state type and width defaults.
package decode_stage_pkg;

  localparam int unsigned IW_DEFAULT = 9;
  localparam int unsigned PW_DEFAULT = 8;

  localparam logic [3:0]  OP_BRZ    = 4'b1110;
  localparam logic [3:0]  OP_HALT   = 4'b1111;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    START,
    RUN,
    FLUSH,
    HALTED
  } state_e;

endpackage

// File: rtl/decode_stage_instr_field_decode.sv
// Combinational field split of an instruction word into opcode, branch offset
// and the two control-opcode flags; every other opcode passes through undecoded.
module instr_field_decode
  import decode_stage_pkg::*;
#(
  parameter int unsigned IW = IW_DEFAULT
) (
  input  logic [IW-1:0] instr_i,
  output logic [3:0]    opcode_o,
  output logic [4:0]    offset_o,
  output logic          is_brz_o,
  output logic          is_halt_o
);

  always_comb begin
    opcode_o  = instr_i[8:5];
    offset_o  = instr_i[4:0];
    is_brz_o  = (instr_i[8:5] == OP_BRZ);
    is_halt_o = (instr_i[8:5] == OP_HALT);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: latches fetched instructions, resolves BRZ against the ALU zero
// flag, squashes the wrong-path slot after a taken branch and stops on HALT.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned IW = IW_DEFAULT,
  parameter int unsigned PW = PW_DEFAULT
) (
  input  logic          CLK,
  input  logic          Init,
  input  logic [IW-1:0] Instr,
  input  logic [PW-1:0] PC,
  input  logic          Zero,
  input  logic          Stall,
  output logic [IW-1:0] InstrD,
  output logic [PW-1:0] PCD,
  output logic          ValidD,
  output logic          Branch,
  output logic [4:0]    Target,
  output logic          Halt,
  output logic [15:0]   InstrCount
);

  state_e        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic          halt_q, halt_d;
  logic [15:0]   count_q, count_d;

  logic [3:0]    unused_opcode;
  logic [4:0]    offset;
  logic          is_brz;
  logic          is_halt;

  instr_field_decode #(.IW(IW)) u_fields (
    .instr_i   (instr_q),
    .opcode_o  (unused_opcode),
    .offset_o  (offset),
    .is_brz_o  (is_brz),
    .is_halt_o (is_halt)
  );

  always_comb begin
    Branch = valid_q & is_brz & Zero & ~Stall & (state_q == RUN);
    Target = Branch ? offset : '0;
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    count_d = count_q;
    if (!Stall) begin
      if (valid_q && (count_q != COUNT_MAX)) count_d = count_q + 16'd1;
      unique case (state_q)
        START, FLUSH: begin
          instr_d = Instr;
          pc_d    = PC;
          valid_d = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          // Taken branch still latches the fall-through word, but marks it squashed.
          if (Branch) begin
            instr_d = Instr;
            pc_d    = PC;
            valid_d = 1'b0;
            state_d = FLUSH;
          end else if (valid_q && is_halt) begin
            valid_d = 1'b0;
            halt_d  = 1'b1;
            state_d = HALTED;
          end else begin
            instr_d = Instr;
            pc_d    = PC;
            valid_d = 1'b1;
          end
        end
        HALTED: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      state_q <= START;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    InstrD     = instr_q;
    PCD        = pc_q;
    ValidD     = valid_q;
    Halt       = halt_q;
    InstrCount = count_q;
  end

endmodule
